// File: rtl/rep_string_wb_seq.sv
// REP/single string-op sequencer driving ECX/ESI/EDI GPR write ports.
// Optional REPE/REPNE ZF termination is enabled by defining REP_ZF_TERM_EN.
module rep_string_wb_seq #(
    parameter logic [2:0] ECX_ID = 3'd1,
    parameter logic [2:0] ESI_ID = 3'd6,
    parameter logic [2:0] EDI_ID = 3'd7
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        START,
    input  logic        REP_EN,
    input  logic [1:0]  OP_SIZE,
    input  logic        DF,
    input  logic        USE_ESI,
    input  logic        USE_EDI,
    input  logic [31:0] ECX_IN,
    input  logic [31:0] ESI_IN,
    input  logic [31:0] EDI_IN,
    input  logic        ITER_ACK,
    input  logic        ABORT,
`ifdef REP_ZF_TERM_EN
    input  logic [1:0]  REP_MODE,
    input  logic        ZF,
`endif
    output logic        ITER_REQ,
    output logic [31:0] GPR_DIN0,
    output logic [31:0] GPR_DIN1,
    output logic [31:0] GPR_DIN2,
    output logic [2:0]  WRGPR0,
    output logic [2:0]  WRGPR1,
    output logic [2:0]  WRGPR2,
    output logic [1:0]  GPRWE0,
    output logic [1:0]  GPRWE1,
    output logic [1:0]  GPRWE2,
    output logic        GPR_WV0,
    output logic        GPR_WV1,
    output logic        GPR_WV2,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WB, S_FIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] ecx_q, ecx_d, esi_q, esi_d, edi_q, edi_d;
    logic        rep_q, rep_d, df_q, df_d;
    logic        use_esi_q, use_esi_d, use_edi_q, use_edi_d;
    logic        abort_q, abort_d;
    logic [2:0]  step_q, step_d;
    logic [31:0] step32, delta, ecx_dec, esi_nxt, edi_nxt;
    logic        zf_stop, stop;

`ifdef REP_ZF_TERM_EN
    logic [1:0]  mode_q, mode_d;
    logic        zf_q, zf_d;
`endif

    assign step32  = {29'd0, step_q};
    assign delta   = df_q ? (32'd0 - step32) : step32;
    assign ecx_dec = ecx_q - 32'd1;
    assign esi_nxt = esi_q + delta;
    assign edi_nxt = edi_q + delta;

`ifdef REP_ZF_TERM_EN
    assign zf_stop = ((mode_q == 2'b10) && !zf_q) ||
                     ((mode_q == 2'b11) && zf_q);
`else
    assign zf_stop = 1'b0;
`endif

    // Abort is only honoured here, after the registers are written back.
    assign stop = !rep_q || (ecx_dec == 32'd0) || ABORT || abort_q || zf_stop;

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q   <= S_IDLE;
            ecx_q     <= 32'd0;
            esi_q     <= 32'd0;
            edi_q     <= 32'd0;
            rep_q     <= 1'b0;
            df_q      <= 1'b0;
            use_esi_q <= 1'b0;
            use_edi_q <= 1'b0;
            abort_q   <= 1'b0;
            step_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            ecx_q     <= ecx_d;
            esi_q     <= esi_d;
            edi_q     <= edi_d;
            rep_q     <= rep_d;
            df_q      <= df_d;
            use_esi_q <= use_esi_d;
            use_edi_q <= use_edi_d;
            abort_q   <= abort_d;
            step_q    <= step_d;
        end
    end

`ifdef REP_ZF_TERM_EN
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            mode_q <= 2'b00;
            zf_q   <= 1'b0;
        end else begin
            mode_q <= mode_d;
            zf_q   <= zf_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        zf_d   = zf_q;
        if (state_q == S_IDLE && START) mode_d = REP_MODE;
        if (state_q == S_REQ && ITER_ACK) zf_d = ZF;
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (START) state_d = (REP_EN && ECX_IN == 32'd0) ? S_FIN : S_REQ;
            S_REQ:  if (ITER_ACK) state_d = S_WB;
            S_WB:   state_d = stop ? S_FIN : S_REQ;
            S_FIN:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ecx_d     = ecx_q;
        esi_d     = esi_q;
        edi_d     = edi_q;
        rep_d     = rep_q;
        df_d      = df_q;
        use_esi_d = use_esi_q;
        use_edi_d = use_edi_q;
        step_d    = step_q;
        abort_d   = abort_q | ABORT;
        unique case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (START) begin
                    ecx_d     = ECX_IN;
                    esi_d     = ESI_IN;
                    edi_d     = EDI_IN;
                    rep_d     = REP_EN;
                    df_d      = DF;
                    use_esi_d = USE_ESI;
                    use_edi_d = USE_EDI;
                    step_d    = (OP_SIZE == 2'b00) ? 3'd1 :
                                (OP_SIZE == 2'b01) ? 3'd2 : 3'd4;
                end
            end
            S_WB: begin
                abort_d = 1'b0;
                if (rep_q)     ecx_d = ecx_dec;
                if (use_esi_q) esi_d = esi_nxt;
                if (use_edi_q) edi_d = edi_nxt;
            end
            default: ;
        endcase
    end

    always_comb begin
        ITER_REQ = (state_q == S_REQ);
        BUSY     = (state_q != S_IDLE);
        DONE     = (state_q == S_FIN);
        GPR_WV0  = (state_q == S_WB) && rep_q;
        GPR_WV1  = (state_q == S_WB) && use_esi_q;
        GPR_WV2  = (state_q == S_WB) && use_edi_q;
        GPR_DIN0 = GPR_WV0 ? ecx_dec : 32'd0;
        GPR_DIN1 = GPR_WV1 ? esi_nxt : 32'd0;
        GPR_DIN2 = GPR_WV2 ? edi_nxt : 32'd0;
        WRGPR0   = ECX_ID;
        WRGPR1   = ESI_ID;
        WRGPR2   = EDI_ID;
        GPRWE0   = 2'b11;
        GPRWE1   = 2'b11;
        GPRWE2   = 2'b11;
    end

endmodule
